// File: rtl/uart_rx_deserializer.sv
// Receive side of the UART datapath: synchronises the serial line, qualifies the
// start bit at mid-bit, samples DATA_BITS data bits LSB first and checks the stop bit.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   S_IDLE      | line idle, waiting for rx_s to go low
//   S_START     | timing half a bit to re-check the start bit at its centre
//   S_DATA      | sampling data bits at each bit centre, LSB first
//   S_STOP      | sampling the stop bit; publishes the byte or flags an error
//   S_WAIT_IDLE | after a framing error, waits for the line to return high
module uart_rx_deserializer #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 i_clock,
  input  logic                 i_resetL,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS) + 1;

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t               state, state_d;
  logic                 rx_meta, rx_s;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [IDX_W-1:0]     idx, idx_d;
  logic [DATA_BITS-1:0] shift, shift_d, shift_in;
  logic [DATA_BITS-1:0] data_d;
  logic                 valid_d, err_d;

  // Synchroniser flops reset to the idle-high line level.
  always_ff @(posedge i_clock) begin
    if (!i_resetL) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_resetL) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_resetL) begin
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      cnt         <= cnt_d;
      idx         <= idx_d;
      shift       <= shift_d;
      o_data      <= data_d;
      o_valid     <= valid_d;
      o_frame_err <= err_d;
    end
  end

  // New bit enters at the MSB end so the first received bit ends up in bit 0.
  always_comb begin
    shift_in = shift;
    for (int i = 0; i < DATA_BITS - 1; i++) begin
      shift_in[i] = shift[i+1];
    end
    shift_in[DATA_BITS-1] = rx_s;
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shift_d = shift;
    data_d  = o_data;
    valid_d = 1'b0;
    err_d   = 1'b0;

    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt == CNT_HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt == CNT_BIT_LAST) begin
          shift_d = shift_in;
          cnt_d   = '0;
          idx_d   = idx + IDX_W'(1);
          if (idx == IDX_LAST) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (cnt == CNT_BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      // A held-low break must not look like a fresh start bit.
      S_WAIT_IDLE: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: default 8-bit/16-clock instance plus a
// 5-bit/4-clock instance; pulses are logged by cycle number and checked per scenario.
module tb_uart_rx_deserializer;

  localparam int CPB  = 16;
  localparam int DB   = 8;
  localparam int CPB2 = 4;
  localparam int DB2  = 5;
  // Two synchroniser flops plus the IDLE detection edge.
  localparam int LAT  = 3;
  localparam int VLAT  = LAT + CPB / 2 + (DB + 1) * CPB;
  localparam int VLAT2 = LAT + CPB2 / 2 + (DB2 + 1) * CPB2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           resetL;
  logic           rx, rx2;
  logic [DB-1:0]  o_data;
  logic           o_valid, o_frame_err, o_busy;
  logic [DB2-1:0] o_data2;
  logic           o_valid2, o_frame_err2, o_busy2;

  uart_rx_deserializer #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB)) dut (
    .i_clock    (clk),
    .i_resetL   (resetL),
    .i_rx       (rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy)
  );

  uart_rx_deserializer #(.DATA_BITS(DB2), .CLKS_PER_BIT(CPB2)) dut2 (
    .i_clock    (clk),
    .i_resetL   (resetL),
    .i_rx       (rx2),
    .o_data     (o_data2),
    .o_valid    (o_valid2),
    .o_frame_err(o_frame_err2),
    .o_busy     (o_busy2)
  );

  int unsigned cyc = 0;
  int checks = 0;
  int failures = 0;

  int unsigned vq[$];
  logic [15:0] dq[$];
  int unsigned eq[$];
  int unsigned vq2[$];
  logic [15:0] dq2[$];
  int unsigned eq2[$];
  int excl_bad = 0;
  int data_bad = 0;
  logic [DB-1:0] prev_data = '0;
  logic rst_at_edge = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_at_edge <= resetL;
  end

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      vq.push_back(cyc);
      dq.push_back(16'(o_data));
    end
    if (o_frame_err === 1'b1) eq.push_back(cyc);
    if (o_valid2 === 1'b1) begin
      vq2.push_back(cyc);
      dq2.push_back(16'(o_data2));
    end
    if (o_frame_err2 === 1'b1) eq2.push_back(cyc);
    if (o_valid === 1'b1 && o_frame_err === 1'b1) excl_bad++;
    if (rst_at_edge === 1'b1 && o_valid !== 1'b1 && o_data !== prev_data) data_bad++;
    prev_data = o_data;
  end

  task automatic clear_logs();
    vq.delete(); dq.delete(); eq.delete();
    vq2.delete(); dq2.delete(); eq2.delete();
  endtask

  task automatic set_line(input logic v, input bit to_inst2);
    if (to_inst2) rx2 = v;
    else rx = v;
  endtask

  task automatic drive_frame(input logic [15:0] data, input int nbits, input logic stop_bit,
                             input int cpb, input bit to_inst2);
    set_line(1'b0, to_inst2);
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      set_line(data[i], to_inst2);
      repeat (cpb) @(negedge clk);
    end
    set_line(stop_bit, to_inst2);
    repeat (cpb) @(negedge clk);
  endtask

  task automatic test_reset();
    resetL = 1'b0;
    rx = 1'b1;
    rx2 = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (o_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", o_data); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", o_frame_err); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (o_data2 !== 5'h00) begin failures++; $display("FAIL reset_data2 got=%h exp=00", o_data2); end
    resetL = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", o_busy); end
  endtask

  task automatic test_single_frame();
    int unsigned c0;
    clear_logs();
    c0 = cyc;
    fork
      drive_frame(16'h00A5, DB, 1'b1, CPB, 1'b0);
      begin
        repeat (40) @(negedge clk);
        checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL a5_busy_mid got=%b exp=1", o_busy); end
      end
    join
    rx = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (vq.size() != 1) begin failures++; $display("FAIL a5_pulses got=%0d exp=1", vq.size()); end
    checks++; if ((vq.size() > 0 ? vq[0] : 0) != c0 + VLAT) begin
      failures++; $display("FAIL a5_time got=%0d exp=%0d", (vq.size() > 0 ? vq[0] : 0), c0 + VLAT); end
    checks++; if ((dq.size() > 0 ? dq[0] : 16'hDEAD) !== 16'h00A5) begin
      failures++; $display("FAIL a5_data got=%h exp=00a5", (dq.size() > 0 ? dq[0] : 16'hDEAD)); end
    checks++; if (eq.size() != 0) begin failures++; $display("FAIL a5_ferr got=%0d exp=0", eq.size()); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL a5_busy_end got=%b exp=0", o_busy); end
    checks++; if (o_data !== 8'hA5) begin failures++; $display("FAIL a5_hold got=%h exp=a5", o_data); end
  endtask

  task automatic test_glitch();
    int unsigned c0;
    clear_logs();
    c0 = cyc;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_start got=%b exp=1 cyc=%0d", o_busy, cyc - c0); end
    @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_reject got=%b exp=0 cyc=%0d", o_busy, cyc - c0); end
    repeat (200) @(negedge clk);
    checks++; if (vq.size() != 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", vq.size()); end
    checks++; if (eq.size() != 0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", eq.size()); end
  endtask

  task automatic test_frame_error();
    int unsigned c0;
    clear_logs();
    c0 = cyc;
    drive_frame(16'h003C, DB, 1'b0, CPB, 1'b0);
    repeat (40) @(negedge clk);
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL ferr_wait_busy got=%b exp=1", o_busy); end
    checks++; if (eq.size() != 1) begin failures++; $display("FAIL ferr_pulses got=%0d exp=1", eq.size()); end
    checks++; if ((eq.size() > 0 ? eq[0] : 0) != c0 + VLAT) begin
      failures++; $display("FAIL ferr_time got=%0d exp=%0d", (eq.size() > 0 ? eq[0] : 0), c0 + VLAT); end
    checks++; if (vq.size() != 0) begin failures++; $display("FAIL ferr_valid got=%0d exp=0", vq.size()); end
    checks++; if (o_data !== 8'hA5) begin failures++; $display("FAIL ferr_data got=%h exp=a5", o_data); end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL ferr_release_busy got=%b exp=0", o_busy); end
    repeat (200) @(negedge clk);
    checks++; if (vq.size() + eq.size() != 1) begin
      failures++; $display("FAIL ferr_spurious got=%0d exp=1", vq.size() + eq.size()); end
  endtask

  task automatic test_back_to_back();
    int unsigned c0;
    clear_logs();
    c0 = cyc;
    drive_frame(16'h0000, DB, 1'b1, CPB, 1'b0);
    drive_frame(16'h00FF, DB, 1'b1, CPB, 1'b0);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (vq.size() != 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", vq.size()); end
    checks++; if ((vq.size() > 0 ? vq[0] : 0) != c0 + VLAT) begin
      failures++; $display("FAIL b2b_time0 got=%0d exp=%0d", (vq.size() > 0 ? vq[0] : 0), c0 + VLAT); end
    checks++; if ((vq.size() > 1 ? vq[1] - vq[0] : 0) != 10 * CPB) begin
      failures++; $display("FAIL b2b_gap got=%0d exp=%0d", (vq.size() > 1 ? vq[1] - vq[0] : 0), 10 * CPB); end
    checks++; if ((dq.size() > 0 ? dq[0] : 16'hDEAD) !== 16'h0000) begin
      failures++; $display("FAIL b2b_data0 got=%h exp=0000", (dq.size() > 0 ? dq[0] : 16'hDEAD)); end
    checks++; if ((dq.size() > 1 ? dq[1] : 16'hDEAD) !== 16'h00FF) begin
      failures++; $display("FAIL b2b_data1 got=%h exp=00ff", (dq.size() > 1 ? dq[1] : 16'hDEAD)); end
    checks++; if (eq.size() != 0) begin failures++; $display("FAIL b2b_ferr got=%0d exp=0", eq.size()); end
  endtask

  task automatic test_reset_abort();
    int unsigned c1;
    logic [7:0] d;
    clear_logs();
    d = 8'h77;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = d[3];
    repeat (CPB / 2) @(negedge clk);
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL abort_busy_pre got=%b exp=1", o_busy); end
    resetL = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    resetL = 1'b1;
    checks++; if (o_data !== 8'h00) begin failures++; $display("FAIL abort_data got=%h exp=00", o_data); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", o_valid); end
    checks++; if (o_frame_err !== 1'b0) begin failures++; $display("FAIL abort_ferr got=%b exp=0", o_frame_err); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", o_busy); end
    repeat (200) @(negedge clk);
    checks++; if (vq.size() + eq.size() != 0) begin
      failures++; $display("FAIL abort_pulses got=%0d exp=0", vq.size() + eq.size()); end
    clear_logs();
    c1 = cyc;
    drive_frame(16'h005A, DB, 1'b1, CPB, 1'b0);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if ((vq.size() > 0 ? vq[0] : 0) != c1 + VLAT) begin
      failures++; $display("FAIL after_abort_time got=%0d exp=%0d", (vq.size() > 0 ? vq[0] : 0), c1 + VLAT); end
    checks++; if ((dq.size() > 0 ? dq[0] : 16'hDEAD) !== 16'h005A) begin
      failures++; $display("FAIL after_abort_data got=%h exp=005a", (dq.size() > 0 ? dq[0] : 16'hDEAD)); end
  endtask

  task automatic test_small_params();
    int unsigned c0;
    clear_logs();
    c0 = cyc;
    drive_frame(16'h0015, DB2, 1'b1, CPB2, 1'b1);
    rx2 = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (vq2.size() != 1) begin failures++; $display("FAIL small_pulses got=%0d exp=1", vq2.size()); end
    checks++; if ((vq2.size() > 0 ? vq2[0] : 0) != c0 + VLAT2) begin
      failures++; $display("FAIL small_time got=%0d exp=%0d", (vq2.size() > 0 ? vq2[0] : 0), c0 + VLAT2); end
    checks++; if ((dq2.size() > 0 ? dq2[0] : 16'hDEAD) !== 16'h0015) begin
      failures++; $display("FAIL small_data got=%h exp=0015", (dq2.size() > 0 ? dq2[0] : 16'hDEAD)); end
    checks++; if (eq2.size() != 0) begin failures++; $display("FAIL small_ferr got=%0d exp=0", eq2.size()); end
    checks++; if (o_busy2 !== 1'b0) begin failures++; $display("FAIL small_busy got=%b exp=0", o_busy2); end
  endtask

  task automatic test_invariants();
    checks++; if (excl_bad != 0) begin failures++; $display("FAIL valid_ferr_overlap got=%0d exp=0", excl_bad); end
    checks++; if (data_bad != 0) begin failures++; $display("FAIL data_change_without_valid got=%0d exp=0", data_bad); end
  endtask

  initial begin
    resetL = 1'b0;
    rx = 1'b1;
    rx2 = 1'b1;
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_abort();
    test_small_params();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
